fv_ct_combine: RTL and testbench

- Downstream of the polynomial multiplier in the FV encryption datapath.
- Consumes the product stream z = p·u mod (x^N+1, 2^QW), the error polynomial e and the plaintext polynomial m, one coefficient per clock.
- Produces the ciphertext component c = z + e + Δ·m mod 2^QW, where Δ = 2^(QW-TW).
- Enforces polynomial framing (N beats, last on beat N-1), absorbs output backpressure with a 2-entry buffer, and drains between polynomials.

---
 rtl/fv_ct_combine_if.sv | 22 ++
 rtl/fv_ct_combine.sv | 170 +++++++++++++++++
 tb/tb_fv_ct_combine.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fv_ct_combine_if.sv
// ============================================================================
//  Module   : axis_if
//  Purpose  : Minimal AXI-stream style bundle (data, vld, rdy, last) used for
//             the product, error, plaintext and ciphertext coefficient streams.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         vld;
    logic         rdy;
    logic         last;

    // Source side drives payload and valid, sink side drives ready
    modport master (output data, output vld, output last, input  rdy);
    modport slave  (input  data, input  vld, input  last, output rdy);
endinterface

`default_nettype wire

// File: rtl/fv_ct_combine.sv
// ============================================================================
//  Module   : fv_ct_combine
//  Purpose  : FV ciphertext combine stage. Computes c = z + e + delta*m
//             mod 2^QW per coefficient (delta = 2^(QW-TW)), enforces
//             N-beat polynomial framing, buffers two output beats against
//             backpressure and drains between polynomials.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fv_ct_combine #(
    parameter int N  = 16,
    parameter int QW = 64,
    parameter int TW = 1,
    parameter int EW = 4
) (
    input  wire logic clk,
    input  wire logic a_rst_n,
    axis_if.slave     z,
    axis_if.slave     e,
    axis_if.slave     m,
    axis_if.master    c,
    output logic      len_err,
    output logic      done
);

    localparam int            CW          = $clog2(N);
    localparam logic [CW-1:0] C_LAST_BEAT = CW'(N - 1);

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    buf_cnt_q;
    logic [QW-1:0] data0_q, data1_q;
    logic          last0_q, last1_q;
    logic          len_err_q, done_q;

    logic          w_rdy;
    logic          w_accept;
    logic          w_pop;
    logic          w_cvld;
    logic          w_at_end;
    logic          w_any_last;
    logic          w_final;
    logic          w_exact;
    logic [QW-1:0] w_e_ext;
    logic [QW-1:0] w_m_ext;
    logic [QW-1:0] w_sum;

    // Input ready depends only on registered state so it never combinationally
    // follows the input valids or the output ready.
    assign w_rdy    = (state_q == ST_STREAM) && (buf_cnt_q < 2'd2);
    assign w_accept = w_rdy && z.vld && e.vld && m.vld;
    assign w_cvld   = (buf_cnt_q != 2'd0);
    assign w_pop    = w_cvld && c.rdy;

    // Any stream flagging last closes the polynomial; only a clean close at
    // beat N-1 with all three lasts set is error-free.
    assign w_at_end   = (cnt_q == C_LAST_BEAT);
    assign w_any_last = z.last || e.last || m.last;
    assign w_final    = w_at_end || w_any_last;
    assign w_exact    = w_at_end && z.last && e.last && m.last;

    // Error is signed and sign-extended; plaintext lands in the top TW bits.
    assign w_e_ext = QW'($signed(e.data));
    assign w_m_ext = QW'(m.data) << (QW - TW);
    assign w_sum   = z.data + w_e_ext + w_m_ext;

    assign z.rdy   = w_rdy;
    assign e.rdy   = w_rdy;
    assign m.rdy   = w_rdy;
    assign c.data  = data0_q;
    assign c.vld   = w_cvld;
    assign c.last  = last0_q && w_cvld;
    assign len_err = len_err_q;
    assign done    = done_q;

    // Next-state and beat counter: framing closes on the final beat and the
    // block waits in drain until that beat leaves on c.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_accept) begin
                    if (w_final) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pop && last0_q) begin
                    state_d = ST_STREAM;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // State, counter and the two one-cycle status pulses.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_err_q <= w_accept && w_final && !w_exact;
            done_q    <= (state_q == ST_DRAIN) && w_pop && last0_q;
        end
    end

    // Two-entry output FIFO; entry 0 is the head presented on c.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            buf_cnt_q <= 2'd0;
            data0_q   <= '0;
            data1_q   <= '0;
            last0_q   <= 1'b0;
            last1_q   <= 1'b0;
        end else begin
            case ({w_accept, w_pop})
                2'b10: begin
                    if (buf_cnt_q == 2'd0) begin
                        data0_q <= w_sum;
                        last0_q <= w_final;
                    end else begin
                        data1_q <= w_sum;
                        last1_q <= w_final;
                    end
                    buf_cnt_q <= buf_cnt_q + 2'd1;
                end
                2'b01: begin
                    data0_q   <= data1_q;
                    last0_q   <= last1_q;
                    buf_cnt_q <= buf_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_q == 2'd2) begin
                        data0_q <= data1_q;
                        last0_q <= last1_q;
                        data1_q <= w_sum;
                        last1_q <= w_final;
                    end else begin
                        data0_q <= w_sum;
                        last0_q <= w_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fv_ct_combine.sv
// ============================================================================
//  Module   : tb_fv_ct_combine
//  Purpose  : Scoreboard bench for fv_ct_combine (N=16, QW=64, TW=1, EW=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fv_ct_combine;

    logic clk = 1'b0;
    logic a_rst_n;
    logic len_err;
    logic done;

    always #5 clk = ~clk;

    axis_if #(.W(64)) z_if ();
    axis_if #(.W(4))  e_if ();
    axis_if #(.W(1))  m_if ();
    axis_if #(.W(64)) c_if ();

    fv_ct_combine #(
        .N  (16),
        .QW (64),
        .TW (1),
        .EW (4)
    ) dut (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .z       (z_if),
        .e       (e_if),
        .m       (m_if),
        .c       (c_if),
        .len_err (len_err),
        .done    (done)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
    } sb_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
        bit          le;
    } rq_t;

    sb_t sb[$];
    rq_t rq[$];

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    int lerr_cnt = 0;

    logic        stall_prev = 1'b0;
    logic [63:0] stall_d    = '0;
    logic        stall_l    = 1'b0;

    function automatic logic [63:0] model(logic [63:0] zd, logic [3:0] ed, logic md);
        return zd + {{60{ed[3]}}, ed} + {md, 63'd0};
    endfunction

    task automatic req(input string nm, input logic [63:0] a, input logic [63:0] x, input bit le = 1'b0);
        rq.push_back('{nm, a, x, le});
    endtask

    // Monitor: all comparisons happen here, on the falling edge
    initial begin
        sb_t h;
        rq_t r;
        forever begin
            @(negedge clk);
            while (rq.size() > 0) begin
                r = rq.pop_front();
                tests++;
                if (r.le ? (r.act > r.exp) : (r.act !== r.exp)) begin
                    fails++;
                    $display("FAIL %s: got %0h, expected %s%0h", r.name, r.act, r.le ? "at most " : "", r.exp);
                end
            end
            if (!a_rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    tests++;
                    if (!c_if.vld || c_if.data !== stall_d || c_if.last !== stall_l) begin
                        fails++;
                        $display("FAIL stall_hold: got vld=%0b data=%0h last=%0b, expected vld=1 data=%0h last=%0b",
                                 c_if.vld, c_if.data, c_if.last, stall_d, stall_l);
                    end
                end
                if (c_if.vld && c_if.rdy) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat: got data=%0h last=%0b, expected no beat", c_if.data, c_if.last);
                    end else begin
                        h = sb.pop_front();
                        if (c_if.data !== h.d || c_if.last !== h.l) begin
                            fails++;
                            $display("FAIL out_beat: got data=%0h last=%0b, expected data=%0h last=%0b",
                                     c_if.data, c_if.last, h.d, h.l);
                        end
                    end
                end
                stall_prev = c_if.vld && !c_if.rdy;
                stall_d    = c_if.data;
                stall_l    = c_if.last;
                if (done)    done_cnt++;
                if (len_err) lerr_cnt++;
            end
        end
    end

    task automatic idle();
        z_if.vld  = 1'b0;
        e_if.vld  = 1'b0;
        m_if.vld  = 1'b0;
        z_if.last = 1'b0;
        e_if.last = 1'b0;
        m_if.last = 1'b0;
    endtask

    // Present one beat, optionally holding e.vld low for e_hold cycles
    task automatic send(input logic [63:0] zd, input logic [3:0] ed, input logic md,
                        input logic zl, input logic el, input logic ml,
                        input logic [63:0] xd, input logic xl, input int e_hold);
        int n = 0;
        bit ok = 1'b0;
        z_if.data = zd;  e_if.data = ed;  m_if.data = md;
        z_if.last = zl;  e_if.last = el;  m_if.last = ml;
        z_if.vld  = 1'b1;
        m_if.vld  = 1'b1;
        e_if.vld  = (e_hold == 0);
        while (n < 100) begin
            @(negedge clk);
            if (z_if.rdy && z_if.vld && e_if.vld && m_if.vld) begin
                ok = 1'b1;
                break;
            end
            n++;
            @(posedge clk);
            #1;
            if (n >= e_hold) e_if.vld = 1'b1;
        end
        if (ok) sb.push_back('{xd, xl});
        req("accept_wait", 64'(n), 64'd99, 1'b1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_std(input int i, input logic zl, input logic el, input logic ml,
                            input logic xl, input int e_hold);
        logic [63:0] zd;
        logic [3:0]  ed;
        logic        md;
        zd = 64'(i) << 8;
        ed = 4'h2;
        md = i[0];
        send(zd, ed, md, zl, el, ml, model(zd, ed, md), xl, e_hold);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (sb.size() == 0 && !c_if.vld) break;
            n++;
        end
        repeat (3) @(negedge clk);
        req(nm, 64'(n), 64'd199, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n   = 1'b0;
        c_if.rdy  = 1'b1;
        z_if.data = '0;
        e_if.data = '0;
        m_if.data = '0;
        idle();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        req("rst_cvld",   64'(c_if.vld), 64'd0);
        req("rst_clast",  64'(c_if.last), 64'd0);
        req("rst_cdata",  c_if.data, 64'd0);
        req("rst_rdy",    64'({z_if.rdy, e_if.rdy, m_if.rdy}), 64'd0);
        req("rst_pulses", 64'({done, len_err}), 64'd0);
        @(posedge clk);
        #1 a_rst_n = 1'b1;
        @(negedge clk);
        req("reset_state_rdy", 64'(z_if.rdy), 64'd0);
        @(negedge clk);
        req("stream_rdy", 64'({z_if.rdy, e_if.rdy, m_if.rdy}), 64'h7);
        @(posedge clk);
        #1;

        // Polynomial A: nominal, with a 2-cycle e.vld gap on beat 3
        send(64'd5, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0004, 1'b0, 0);
        req("first_latency_vld",  64'(c_if.vld), 64'd1);
        req("first_latency_data", c_if.data, 64'h8000_0000_0000_0004);
        for (int i = 1; i < 16; i++)
            send_std(i, i == 15, i == 15, i == 15, i == 15, (i == 3) ? 2 : 0);
        idle();
        drain("drain_a");
        req("done_a", 64'(done_cnt), 64'd1);
        req("lerr_a", 64'(lerr_cnt), 64'd0);

        // Polynomial B: wrap-around vectors plus a 3-cycle output stall
        fork
            begin
                send(64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 0);
                send(64'h0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 0);
                for (int i = 2; i < 16; i++)
                    send_std(i, i == 15, i == 15, i == 15, i == 15, 0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 c_if.rdy = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                req("bp_rdy_low", 64'(z_if.rdy), 64'd0);
                @(posedge clk);
                #1 c_if.rdy = 1'b1;
            end
        join
        idle();
        drain("drain_b");
        req("done_b", 64'(done_cnt), 64'd2);
        req("lerr_b", 64'(lerr_cnt), 64'd0);

        // Polynomial C: early last on z at beat 9
        for (int i = 0; i < 10; i++)
            send_std(i, i == 9, 1'b0, 1'b0, i == 9, 0);
        req("drain_rdy", 64'(z_if.rdy), 64'd0);
        idle();
        drain("drain_c");
        req("done_c", 64'(done_cnt), 64'd3);
        req("lerr_c", 64'(lerr_cnt), 64'd1);

        // Polynomial D: no last at all, closed by the beat count
        for (int i = 0; i < 16; i++)
            send_std(i, 1'b0, 1'b0, 1'b0, i == 15, 0);
        idle();
        drain("drain_d");
        req("done_d", 64'(done_cnt), 64'd4);
        req("lerr_d", 64'(lerr_cnt), 64'd2);

        // Reset mid-polynomial with the buffer full
        for (int i = 0; i < 6; i++)
            send_std(i, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        c_if.rdy = 1'b0;
        send_std(6, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle();
        @(negedge clk);
        req("full_rdy", 64'(z_if.rdy), 64'd0);
        #2 a_rst_n = 1'b0;
        #1;
        req("midrst_cvld", 64'(c_if.vld), 64'd0);
        req("midrst_rdy",  64'(z_if.rdy), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 a_rst_n = 1'b1;
        c_if.rdy = 1'b1;
        @(negedge clk);
        req("post_midrst_rdy", 64'(z_if.rdy), 64'd0);
        @(posedge clk);
        #1;

        // Polynomial E: fresh polynomial after reset
        for (int i = 0; i < 16; i++)
            send_std(i, i == 15, i == 15, i == 15, i == 15, 0);
        idle();
        drain("drain_e");
        req("done_e", 64'(done_cnt), 64'd5);
        req("lerr_e", 64'(lerr_cnt), 64'd2);
        req("sb_empty", 64'(sb.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
